// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg: types and constants shared by the conv kernel and its output
// drain logic.
//   DEF_COL / DEF_OFM_WIDTH : default column count and result width
//   COL_IDX_W               : width of a column index
//   sum_t                   : one signed kernel result word
//   drain_state_e           : run-state encoding of ofm_drain
// ---------------------------------------------------------------------------
package conv_pkg;

  localparam int DEF_COL       = 8;
  localparam int DEF_OFM_WIDTH = 32;
  localparam int COL_IDX_W     = $clog2(DEF_COL);

  typedef logic signed [DEF_OFM_WIDTH-1:0] sum_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } drain_state_e;

endpackage

// File: rtl/ofm_fifo.sv
// ---------------------------------------------------------------------------
// ofm_fifo: synchronous show-ahead FIFO. The head entry is always visible on
// dout while empty is low, so a consumer can inspect it before popping.
//   clk, rstn : clock and asynchronous active-low reset (pointers only)
//   push, din : write request and data (ignored when full unless popping)
//   pop       : read request (ignored when empty)
//   dout      : head entry
//   full      : DEPTH entries stored
//   empty     : no entries stored
// ---------------------------------------------------------------------------
module ofm_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // One extra pointer bit distinguishes full from empty when indices match.
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage carries no reset; stale words are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ofm_drain.sv
// ---------------------------------------------------------------------------
// ofm_drain: receive side of the conv kernel output. Per-column results are
// captured into hold registers, picked one per cycle by a round-robin
// arbiter, queued in a show-ahead FIFO and delivered as a valid/ready stream
// tagged with the source column.
//   clk, rstn             : clock, asynchronous active-low reset
//   start_conv, conv_done : run start / kernel completion pulses
//   sum_valid, sum        : per-column result strobes and values
//   out_valid, out_ready  : output stream handshake
//   out_data, out_col     : delivered word and its column
//   ofm_count             : results delivered this run (saturating)
//   overflow              : sticky, a result arrived while its column was busy
//   drain_done            : one-cycle pulse once the run has fully drained
// ---------------------------------------------------------------------------
module ofm_drain
  import conv_pkg::*;
#(
  parameter int COL        = DEF_COL,
  parameter int OFM_WIDTH  = DEF_OFM_WIDTH,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        start_conv,
  input  logic                        conv_done,
  input  logic [COL-1:0]              sum_valid,
  input  logic signed [OFM_WIDTH-1:0] sum [COL],
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OFM_WIDTH-1:0] out_data,
  output logic [$clog2(COL)-1:0]      out_col,
  output logic [CNT_WIDTH-1:0]        ofm_count,
  output logic                        overflow,
  output logic                        drain_done
);

  localparam int CW = $clog2(COL);
  localparam int FW = OFM_WIDTH + CW;

  drain_state_e                state_q, state_d;
  logic [COL-1:0]              pend_q, pend_d;
  logic signed [OFM_WIDTH-1:0] hold_q [COL];
  logic [CW-1:0]               ptr_q;
  logic [CNT_WIDTH-1:0]        ofm_count_q;
  logic                        overflow_q, drain_done_q;

  logic                        fifo_full, fifo_empty, fifo_pop;
  logic [FW-1:0]               fifo_din, fifo_dout;

  logic                        gnt_vld;
  logic [CW-1:0]               gnt_idx, scan_idx;
  logic [COL-1:0]              gnt_oh, cap_ok;
  logic                        cap_en, lost, start_ok;

  assign cap_en   = (state_q == RUN) || (state_q == FLUSH);
  assign start_ok = start_conv && ((state_q == IDLE) || (state_q == DONE));

  // Round-robin search starting at ptr_q. Uses the pre-pop full flag so a
  // grant never depends on this cycle's downstream handshake.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    gnt_oh   = '0;
    scan_idx = '0;
    if (!fifo_full) begin
      for (int i = 0; i < COL; i++) begin
        scan_idx = (int'(ptr_q) + i >= COL) ? CW'(int'(ptr_q) + i - COL)
                                            : CW'(int'(ptr_q) + i);
        if (!gnt_vld && pend_q[scan_idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = scan_idx;
        end
      end
    end
    if (gnt_vld) gnt_oh[gnt_idx] = 1'b1;
  end

  // A column being granted this cycle frees its hold register, so a new
  // result for it is accepted; any other busy column drops the new value.
  generate
    for (genvar gi = 0; gi < COL; gi++) begin : g_hold
      assign cap_ok[gi] = cap_en && sum_valid[gi] && (!pend_q[gi] || gnt_oh[gi]);
      always_ff @(posedge clk) begin
        if (cap_ok[gi]) hold_q[gi] <= sum[gi];
      end
    end
  endgenerate

  assign lost   = cap_en && |(sum_valid & pend_q & ~gnt_oh);
  assign pend_d = (pend_q & ~gnt_oh) | (cap_en ? sum_valid : '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start_ok) state_d = RUN;
      RUN:   if (conv_done) state_d = FLUSH;
      FLUSH: if ((pend_q == '0) && fifo_empty && (sum_valid == '0)) state_d = DONE;
      DONE:  state_d = start_ok ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      pend_q       <= '0;
      ptr_q        <= '0;
      ofm_count_q  <= '0;
      overflow_q   <= 1'b0;
      drain_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_done_q <= (state_d == DONE);
      pend_q       <= pend_d;
      if (start_ok) begin
        ptr_q       <= '0;
        ofm_count_q <= '0;
        overflow_q  <= 1'b0;
      end else begin
        if (gnt_vld) ptr_q <= (gnt_idx == CW'(COL - 1)) ? '0 : gnt_idx + 1'b1;
        if (fifo_pop && (ofm_count_q != '1)) ofm_count_q <= ofm_count_q + 1'b1;
        if (lost) overflow_q <= 1'b1;
      end
    end
  end

  assign fifo_din = {gnt_idx, hold_q[gnt_idx]};
  assign fifo_pop = !fifo_empty && out_ready;

  ofm_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (gnt_vld),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Data/column are forced to zero while empty so nothing stale is exposed.
  assign out_valid  = !fifo_empty;
  assign out_data   = fifo_empty ? '0 : fifo_dout[OFM_WIDTH-1:0];
  assign out_col    = fifo_empty ? '0 : fifo_dout[FW-1:OFM_WIDTH];
  assign ofm_count  = ofm_count_q;
  assign overflow   = overflow_q;
  assign drain_done = drain_done_q;

endmodule

// File: tb/tb_ofm_drain.sv
module tb_ofm_drain;
  import conv_pkg::*;

  localparam int NCOL   = 8;
  localparam int DEPTH  = 16;
  localparam int MAXCNT = 65535;
  localparam int S_IDLE = 0, S_RUN = 1, S_FLUSH = 2, S_DONE = 3;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 start_conv, conv_done, out_ready;
  logic [NCOL-1:0]      sum_valid;
  sum_t                 sum [NCOL];
  logic                 out_valid, overflow, drain_done;
  sum_t                 out_data;
  logic [COL_IDX_W-1:0] out_col;
  logic [15:0]          ofm_count;

  always #5 clk = ~clk;

  ofm_drain #(.COL(NCOL), .OFM_WIDTH(32), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(16)) dut (
    .clk(clk), .rstn(rstn), .start_conv(start_conv), .conv_done(conv_done),
    .sum_valid(sum_valid), .sum(sum), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_col(out_col), .ofm_count(ofm_count),
    .overflow(overflow), .drain_done(drain_done)
  );

  typedef struct { int col; int data; } beat_t;

  int vectors = 0, miscompares = 0;
  int edge_n = 0, last_pop_edge = 0, dd_edge = 0, dd_count = 0;
  bit verbose = 1;
  beat_t beats[$];

  // Reference model: pending flags and held values per column, a queue for
  // the output buffer, and the run state as a plain integer.
  int    m_state, m_ptr, m_cnt;
  bit    m_ovf, m_dd;
  bit    m_pend [NCOL];
  int    m_hold [NCOL];
  beat_t m_q[$];

  function automatic void chk(string name, logic signed [63:0] act, logic signed [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endfunction

  function automatic void model_reset();
    m_state = S_IDLE; m_ptr = 0; m_cnt = 0; m_ovf = 0; m_dd = 0;
    for (int k = 0; k < NCOL; k++) begin m_pend[k] = 0; m_hold[k] = 0; end
    m_q.delete();
  endfunction

  function automatic void model_edge();
    bit pop, full, capen, quiet, start_ok;
    int g, c;
    pop      = (m_q.size() > 0) && out_ready;
    full     = (m_q.size() == DEPTH);
    capen    = (m_state == S_RUN) || (m_state == S_FLUSH);
    quiet    = (m_q.size() == 0) && (sum_valid == 0);
    start_ok = start_conv && (m_state == S_IDLE || m_state == S_DONE);
    for (int k = 0; k < NCOL; k++) if (m_pend[k]) quiet = 0;
    g = -1;
    if (!full)
      for (int k = 0; k < NCOL; k++) begin
        c = (m_ptr + k) % NCOL;
        if (g < 0 && m_pend[c]) g = c;
      end
    if (pop) void'(m_q.pop_front());
    if (g >= 0) begin
      m_q.push_back('{col: g, data: m_hold[g]});
      m_pend[g] = 0;
      m_ptr = (g + 1) % NCOL;
    end
    if (capen)
      for (int k = 0; k < NCOL; k++)
        if (sum_valid[k]) begin
          if (m_pend[k]) m_ovf = 1;
          else begin m_hold[k] = sum[k]; m_pend[k] = 1; end
        end
    if (start_ok) begin m_cnt = 0; m_ovf = 0; m_ptr = 0; end
    else if (pop && m_cnt < MAXCNT) m_cnt++;
    case (m_state)
      S_IDLE:  if (start_ok) m_state = S_RUN;
      S_RUN:   if (conv_done) m_state = S_FLUSH;
      S_FLUSH: if (quiet) m_state = S_DONE;
      default: m_state = start_ok ? S_RUN : S_IDLE;
    endcase
    m_dd = (m_state == S_DONE);
  endfunction

  function automatic void compare();
    chk("out_valid", out_valid, m_q.size() > 0);
    if (m_q.size() > 0) begin
      chk("out_col", out_col, m_q[0].col);
      chk("out_data", out_data, m_q[0].data);
    end
    chk("ofm_count", ofm_count, m_cnt);
    chk("overflow", overflow, m_ovf);
    chk("drain_done", drain_done, m_dd);
  endfunction

  // One clock: log the beat accepted at this edge, advance the model, compare.
  task automatic cycle();
    bit popped;
    popped = out_valid && out_ready;
    if (popped) begin
      beats.push_back('{col: int'(out_col), data: int'(out_data)});
      if (verbose) $display("beat col=%0d data=%0d count_before=%0d", out_col, out_data, ofm_count);
    end
    @(posedge clk);
    edge_n++;
    if (popped) last_pop_edge = edge_n;
    model_edge();
    #1;
    compare();
    if (drain_done) begin dd_count++; dd_edge = edge_n; end
  endtask

  task automatic start_run();
    start_conv = 1'b1; cycle(); start_conv = 1'b0;
  endtask

  task automatic inject(input logic [NCOL-1:0] mask);
    sum_valid = mask; cycle(); sum_valid = '0;
  endtask

  // Pulse conv_done and run until drain_done; returns edges from last beat.
  task automatic finish_run(output int gap);
    int n;
    dd_count = 0;
    conv_done = 1'b1; cycle(); conv_done = 1'b0;
    n = 0;
    while (dd_count == 0 && n < 300) begin cycle(); n++; end
    if (dd_count == 0) chk("drain_timeout", 0, 1);
    gap = dd_edge - last_pop_edge;
    repeat (3) cycle();
    chk("drain_done_pulses", dd_count, 1);
  endtask

  typedef struct { logic [NCOL-1:0] mask; int col; int val; int exp_col; int exp_val; } vec_t;
  vec_t tv [6];

  initial begin
    int gap;
    tv[0] = '{8'h04, 2, -5, 2, -5};
    tv[1] = '{8'h01, 0, 32'h7FFFFFFF, 0, 32'h7FFFFFFF};
    tv[2] = '{8'h80, 7, 32'h80000000, 7, 32'h80000000};
    tv[3] = '{8'h10, 4, 0, 4, 0};
    tv[4] = '{8'h02, 1, 123456, 1, 123456};
    tv[5] = '{8'h40, 6, -1, 6, -1};

    rstn = 1'b0; start_conv = 0; conv_done = 0; out_ready = 1; sum_valid = '0;
    for (int k = 0; k < NCOL; k++) sum[k] = '0;
    model_reset();
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_col", out_col, 0);
    chk("rst_ofm_count", ofm_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drain_done", drain_done, 0);
    #10 rstn = 1'b1;

    // Single-result vectors: two-cycle latency, column tag and count.
    start_run();
    for (int i = 0; i < 6; i++) begin
      sum[tv[i].col] = tv[i].val;
      inject(tv[i].mask);
      chk("tv_not_yet_valid", out_valid, 0);
      cycle();
      chk("tv_valid", out_valid, 1);
      chk("tv_col", out_col, tv[i].exp_col);
      chk("tv_data", out_data, tv[i].exp_val);
      cycle();
      chk("tv_count", ofm_count, i + 1);
    end
    finish_run(gap);

    // Full burst, consecutive beats in column order.
    start_run();
    chk("burst_count_clear", ofm_count, 0);
    for (int k = 0; k < NCOL; k++) sum[k] = k * 10;
    beats.delete();
    inject(8'hFF);
    repeat (10) cycle();
    chk("burst_beats", beats.size(), 8);
    for (int k = 0; k < beats.size(); k++) begin
      chk("burst_col", beats[k].col, k);
      chk("burst_data", beats[k].data, k * 10);
    end
    chk("burst_count", ofm_count, 8);
    finish_run(gap);

    // Round robin: col 3 granted while col 0 and a new col 3 arrive.
    start_run();
    beats.delete();
    sum[3] = 300; inject(8'h08);
    sum[0] = 100; sum[3] = 301; inject(8'h09);
    repeat (6) cycle();
    chk("rr_beats", beats.size(), 3);
    if (beats.size() == 3) begin
      chk("rr_col0", beats[0].col, 3); chk("rr_dat0", beats[0].data, 300);
      chk("rr_col1", beats[1].col, 0); chk("rr_dat1", beats[1].data, 100);
      chk("rr_col2", beats[2].col, 3); chk("rr_dat2", beats[2].data, 301);
    end
    chk("rr_overflow", overflow, 0);
    finish_run(gap);

    // Backpressure: two bursts fill the FIFO, a third sits pending, a fourth is lost.
    start_run();
    out_ready = 0;
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < NCOL; k++) sum[k] = 1000 + b * 100 + k;
      inject(8'hFF);
      repeat (9) cycle();
      if (b == 2) chk("bp_no_overflow_yet", overflow, 0);
    end
    chk("bp_overflow", overflow, 1);
    chk("bp_valid_held", out_valid, 1);
    beats.delete();
    out_ready = 1;
    finish_run(gap);
    chk("bp_beats", beats.size(), 24);
    if (beats.size() == 24)
      for (int k = 0; k < NCOL; k++) begin
        chk("bp_first_burst", beats[k].data, 1000 + k);
        chk("bp_third_burst", beats[16 + k].data, 1200 + k);
      end
    chk("bp_done_gap", gap, 1);
    chk("bp_final_count", ofm_count, 24);
    start_run();
    chk("restart_count", ofm_count, 0);
    chk("restart_overflow", overflow, 0);

    // Flush with five entries queued.
    out_ready = 0;
    for (int k = 0; k < NCOL; k++) sum[k] = -(k + 1);
    inject(8'h1F);
    repeat (7) cycle();
    beats.delete();
    out_ready = 1;
    finish_run(gap);
    chk("flush_beats", beats.size(), 5);
    chk("flush_done_gap", gap, 1);

    // Reset mid-run with six entries buffered and overflow set.
    start_run();
    out_ready = 0;
    for (int k = 0; k < NCOL; k++) sum[k] = 50 + k;
    inject(8'hFF);
    inject(8'hFF);
    repeat (10) cycle();
    out_ready = 1;
    repeat (3) cycle();
    out_ready = 0;
    #3 rstn = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_count", ofm_count, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_data", out_data, 0);
    model_reset();
    #12 rstn = 1'b1;
    beats.delete();
    out_ready = 1;
    repeat (10) cycle();
    chk("stale_beats", beats.size(), 0);

    // Randomized traffic against the model.
    verbose = 0;
    start_run();
    for (int i = 0; i < 2000; i++) begin
      for (int k = 0; k < NCOL; k++) begin
        sum_valid[k] = ($urandom_range(0, 3) == 0);
        sum[k] = $urandom;
      end
      out_ready  = ($urandom_range(0, 9) < 7);
      conv_done  = ($urandom_range(0, 59) == 0);
      start_conv = ($urandom_range(0, 39) == 0);
      cycle();
    end
    sum_valid = '0; conv_done = 0; start_conv = 0; out_ready = 1;
    repeat (40) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
